// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: time-slices NUM_DIGITS BCD digits onto one
// segment bus with frame-aligned display updates, per-digit blanking and blink.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W  = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        POL_LO = (ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_OFF = {7{POL_LO}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL_LO}};

  // Active-low abcdefg patterns; 15 is a dash, 10..14 are dark.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd15:   s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic [DATA_W-1:0]     pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  phase_q, phase_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  presc_wrap;
  logic                  idx_last;
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic                  dark;
  logic [6:0]            seg_low;
  logic [NUM_DIGITS-1:0] an_low;

  always_comb begin
    presc_d       = presc_q + PRE_W'(1);
    idx_d         = idx_q;
    disp_d        = disp_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    blk_cnt_d     = blk_cnt_q;
    phase_d       = phase_q;
    an_low        = '1;

    presc_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));
    idx_last   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_wrap = presc_wrap && idx_last;

    if (presc_wrap) begin
      presc_d = '0;
      idx_d   = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    // Old pending moves to the display at the wrap; a same-cycle load refills pending.
    if (frame_wrap && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d       = digits_in;
      pend_valid_d = 1'b1;
    end

    if (frame_wrap) begin
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end

    nib     = disp_q[{idx_q, 2'b00} +: 4];
    dark    = blank_mask[idx_q] | (blink_en & blink_mask[idx_q] & phase_q);
    seg_low = dark ? 7'b1111111 : decode(nib);
    an_low[idx_q] = 1'b0;

    seg_d        = seg_low ^ {7{~POL_LO}};
    an_d         = an_low ^ {NUM_DIGITS{~POL_LO}};
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      blk_cnt_q    <= '0;
      phase_q      <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      blk_cnt_q    <= blk_cnt_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver; expectations come from a
// cycle-arithmetic model of the scan, load history and blink schedule.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int F  = N * RD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits_in = '0;
  logic          load = 1'b0;
  logic [N-1:0]  blank_mask = '0;
  logic          blink_en = 1'b0;
  logic [N-1:0]  blink_mask = '0;
  logic [6:0]    seg_out;
  logic [N-1:0]  an_out;
  logic          frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
    .blank_mask(blank_mask), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t        exp_q[$];
  int          load_edge[$];
  logic [15:0] load_val[$];
  int          t = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_req = 1'b1;
  logic [N-1:0] bm_r = '0;
  logic [N-1:0] blm_r = '0;
  logic        ben_r = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'd15: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Display content in state s is the last load strictly before the latest frame boundary.
  function automatic logic [15:0] shown(input int s);
    int b;
    logic [15:0] v;
    b = (s / F) * F;
    v = '0;
    foreach (load_edge[i]) if (load_edge[i] < b) v = load_val[i];
    return v;
  endfunction

  // One cycle: drive inputs on the falling edge, predict the next rising-edge outputs.
  task automatic step(input logic ld, input logic [15:0] d);
    exp_t e;
    int s, idx, ph;
    logic [15:0] v;
    logic [3:0] nb;
    logic dk;
    @(negedge clk);
    rst = rst_req;
    load = ld;
    digits_in = d;
    blank_mask = bm_r;
    blink_mask = blm_r;
    blink_en = ben_r;
    if (rst) begin
      t = 0;
      load_edge.delete();
      load_val.delete();
      e.seg = 7'h7F;
      e.an = '1;
      e.fd = 1'b0;
    end else begin
      s   = t;
      idx = (s / RD) % N;
      ph  = ((s / F) / BF) % 2;
      v   = shown(s);
      nb  = 4'(v >> (4 * idx));
      dk  = bm_r[idx] || (ben_r && blm_r[idx] && (ph == 1));
      e.seg = dk ? 7'h7F : ref_seg(nb);
      e.an  = ~(N'(1) << idx);
      e.fd  = ((t + 1) % F) == 0;
      if (ld) begin
        load_edge.push_back(t + 1);
        load_val.push_back(d);
      end
      t++;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("seg_out", 32'(seg_out), 32'(e.seg));
        chk("an_out", 32'(an_out), 32'(e.an));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  initial begin : driver
    repeat (3) step(1'b0, 16'h0);
    rst_req = 1'b0;
    repeat (40) step(1'b0, 16'h0);

    repeat (2) step(1'b0, 16'h0);
    step(1'b1, 16'h1234);
    repeat (40) step(1'b0, 16'h0);

    step(1'b1, 16'h9FAB);
    repeat (3) step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    repeat (40) step(1'b0, 16'h0);

    step(1'b1, 16'hFAB3);
    repeat (40) step(1'b0, 16'h0);

    ben_r = 1'b1;
    blm_r = 4'b0001;
    bm_r  = 4'b0100;
    repeat (180) step(1'b0, 16'h0);
    ben_r = 1'b0;
    blm_r = '0;
    bm_r  = '0;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) begin
        bm_r  = N'($urandom);
        blm_r = N'($urandom);
        ben_r = 1'($urandom);
      end
      step(($urandom_range(11) == 0), 16'($urandom));
    end
    bm_r = '0;
    blm_r = '0;
    ben_r = 1'b0;

    // Asynchronous reset in the digit-2 slot with a load still pending.
    while ((t % F) != 1) step(1'b0, 16'h0);
    step(1'b1, 16'h7777);
    while (((t / RD) % N) != 2) step(1'b0, 16'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg_out), 32'h7F);
    chk("async_rst_an", 32'(an_out), 32'hF);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    repeat (3) step(1'b0, 16'h0);
    rst_req = 1'b0;
    repeat (40) step(1'b0, 16'h0);

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
